dlsc_demosaic_mosaic: RTL and testbench

Re-mosaic (encoder) stage, the inverse of the demosaic output path. It accepts full RGB pixels in raster order and emits one Bayer sample per pixel. The emitted colour channel is chosen from the pixel's (x,y) position and a configurable CFA phase. It is used to generate synthetic Bayer frames for the demosaic pipeline, and for round-trip test and loopback paths, with ready/valid flow control and row/frame markers.

---
 rtl/dlsc_demosaic_mosaic.sv | 146 ++++++++++++++
 tb/tb_dlsc_demosaic_mosaic.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_demosaic_mosaic.sv
`default_nettype none
//==============================================================================
// Module      : dlsc_demosaic_mosaic
// Description : Re-mosaic encoder. Picks one Bayer sample per RGB pixel from its
//               (x,y) position and the CFA phase. Output register plus skid entry.
// Revision    : 1.0 - initial release
//==============================================================================
module dlsc_demosaic_mosaic #(
    parameter int DATA = 8,
    parameter int XB   = 12,
    parameter int YB   = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [XB-1:0]   cfg_width,
    input  logic [YB-1:0]   cfg_height,
    input  logic [1:0]      cfg_pattern,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [DATA-1:0] in_red,
    input  logic [DATA-1:0] in_green,
    input  logic [DATA-1:0] in_blue,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DATA-1:0] out_data,
    output logic            out_last,
    output logic            out_frame
);

    logic [XB-1:0]   r_x;
    logic [YB-1:0]   r_y;
    logic [XB-1:0]   r_width;
    logic [YB-1:0]   r_height;
    logic [1:0]      r_pattern;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DATA-1:0] r_out_data;
    logic            r_out_last;
    logic            r_out_frame;
    logic            r_skid_valid;
    logic [DATA-1:0] r_skid_data;
    logic            r_skid_last;
    logic            r_skid_frame;

    logic            w_in_xfer;
    logic            w_first;
    logic [XB-1:0]   w_width;
    logic [YB-1:0]   w_height;
    logic [1:0]      w_pattern;
    logic            w_px;
    logic            w_py;
    logic [DATA-1:0] w_sample;
    logic            w_last;
    logic            w_frame;

    assign w_in_xfer = clk_en && in_valid && r_in_ready;

    // Pixel (0,0) sees the live config ports, since the latch only updates on its transfer
    assign w_first   = (r_x == '0) && (r_y == '0);
    assign w_width   = w_first ? cfg_width   : r_width;
    assign w_height  = w_first ? cfg_height  : r_height;
    assign w_pattern = w_first ? cfg_pattern : r_pattern;

    assign w_px = r_x[0] ^ w_pattern[0];
    assign w_py = r_y[0] ^ w_pattern[1];

    always_comb begin
        w_sample = in_green;
        if (!w_px && !w_py) begin
            w_sample = in_red;
        end else if (w_px && w_py) begin
            w_sample = in_blue;
        end
    end

    assign w_last  = (r_x == w_width);
    assign w_frame = w_last && (r_y == w_height);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_pattern    <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_frame  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_frame <= 1'b0;
        end else if (clk_en) begin
            if (w_in_xfer) begin
                if (w_first) begin
                    r_width   <= cfg_width;
                    r_height  <= cfg_height;
                    r_pattern <= cfg_pattern;
                end
                if (w_last) begin
                    r_x <= '0;
                    r_y <= w_frame ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end

            // A full skid entry blocks input, so it only drains into the output register
            if (r_skid_valid) begin
                if (out_ready) begin
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_out_frame  <= r_skid_frame;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            end else if (w_in_xfer) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_sample;
                    r_out_last  <= w_last;
                    r_out_frame <= w_frame;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_sample;
                    r_skid_last  <= w_last;
                    r_skid_frame <= w_frame;
                    r_in_ready   <= 1'b0;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_frame = r_out_frame;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_demosaic_mosaic.sv
`default_nettype none
//==============================================================================
// Module      : tb_dlsc_demosaic_mosaic
// Description : Scoreboard bench for the re-mosaic encoder.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dlsc_demosaic_mosaic;

    localparam int DATA = 8;
    localparam int XB   = 12;
    localparam int YB   = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clk_en = 1'b1;
    logic [XB-1:0]   cfg_width = '0;
    logic [YB-1:0]   cfg_height = '0;
    logic [1:0]      cfg_pattern = '0;
    logic            in_ready;
    logic            in_valid = 1'b0;
    logic [DATA-1:0] in_red = '0;
    logic [DATA-1:0] in_green = '0;
    logic [DATA-1:0] in_blue = '0;
    logic            out_ready = 1'b1;
    logic            out_valid;
    logic [DATA-1:0] out_data;
    logic            out_last;
    logic            out_frame;

    dlsc_demosaic_mosaic #(.DATA(DATA), .XB(XB), .YB(YB)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_pattern(cfg_pattern),
        .in_ready(in_ready), .in_valid(in_valid),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_frame(out_frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA-1:0] d;
        logic            l;
        logic            f;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0: high, 1: repeating 1,0,0,1, 2: low
    int   rcnt = 0;

    // Reference position and per-frame latched config
    int          mx = 0, my = 0;
    int          lw = 0, lh = 0;
    logic [1:0]  lp = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA-1:0] pick(input int x, input int y, input logic [1:0] pat,
                                             input logic [DATA-1:0] r, input logic [DATA-1:0] g,
                                             input logic [DATA-1:0] b);
        logic px, py;
        px = (x % 2 == 1) ^ pat[0];
        py = (y % 2 == 1) ^ pat[1];
        if (!px && !py) return r;
        if (px && py)   return b;
        return g;
    endfunction

    task automatic push_expected();
        exp_t e;
        if (mx == 0 && my == 0) begin
            lw = int'(cfg_width);
            lh = int'(cfg_height);
            lp = cfg_pattern;
        end
        e.d = pick(mx, my, lp, in_red, in_green, in_blue);
        e.l = (mx == lw);
        e.f = e.l && (my == lh);
        q.push_back(e);
        if (mx == lw) begin
            mx = 0;
            my = (my == lh) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge
    task automatic send(input logic [DATA-1:0] r, input logic [DATA-1:0] g,
                        input logic [DATA-1:0] b, input bit chk_lat);
        in_red = r; in_green = g; in_blue = b; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready && clk_en) begin
                push_expected();
                @(posedge clk); #1;
                in_valid = 1'b0;
                if (chk_lat) check("latency_out_valid", out_valid, 1);
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout_in_ready", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) return;
            @(posedge clk); #1;
        end
        check("drain_timeout_pending", q.size(), 0);
    endtask

    task automatic send_frame(input int n, input bit chk_lat);
        for (int i = 0; i < n; i++) begin
            send(8'(mx + 16 * my), 8'h80 ^ 8'(i), 8'hF0 - 8'(i), chk_lat);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                rcnt++;
            end
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard pop and stall stability
    logic        hold = 1'b0;
    logic [31:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid_kept", out_valid, 1);
                check("stall_data_stable", {out_data, out_last, out_frame}, held);
            end
            if (out_valid && out_ready && clk_en) begin
                if (q.size() == 0) begin
                    check("spurious_output", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.l);
                    check("out_frame", out_frame, e.f);
                end
            end
            hold = out_valid && !(out_ready && clk_en);
            held = {out_data, out_last, out_frame};
        end
    end

    // Occupancy: in_ready low exactly while skid holds a sample
    always @(posedge clk) begin
        #3;
        if (!rst) begin
            check("in_ready_occupancy", in_ready, q.size() < 2);
            check("out_valid_occupancy", out_valid, q.size() != 0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_frame", out_frame, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // RGGB 4x2 frame, then BGGR
        cfg_width = 12'd3; cfg_height = 12'd1; cfg_pattern = 2'd0;
        for (int i = 0; i < 8; i++) send(8'((i % 4) + 16 * (i / 4)), 8'h80, 8'hF0, 1'b1);
        drain();
        cfg_pattern = 2'd3;
        for (int i = 0; i < 8; i++) send(8'((i % 4) + 16 * (i / 4)), 8'h80, 8'hF0, 1'b1);
        drain();

        // Backpressure 1,0,0,1 over a 64-pixel frame
        cfg_width = 12'd7; cfg_height = 12'd7; cfg_pattern = 2'd1;
        rcnt = 0; ready_mode = 1;
        send_frame(64, 1'b0);
        drain();
        ready_mode = 0;
        @(posedge clk); #1;

        // Pattern change mid-frame takes effect on the next frame only
        cfg_width = 12'd3; cfg_height = 12'd1; cfg_pattern = 2'd0;
        send_frame(5, 1'b0);
        cfg_pattern = 2'd1;
        send_frame(3, 1'b0);
        send_frame(8, 1'b0);
        drain();

        // Asynchronous reset mid-row
        cfg_width = 12'd7; cfg_height = 12'd1; cfg_pattern = 2'd2;
        send_frame(5, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        q.delete();
        mx = 0; my = 0;
        @(posedge clk); #4 rst = 1'b0;
        @(posedge clk); #1;
        cfg_width = 12'd3; cfg_height = 12'd1; cfg_pattern = 2'd2;
        send_frame(8, 1'b0);
        drain();

        // Clock enable low during a full stall
        cfg_width = 12'd3; cfg_height = 12'd1; cfg_pattern = 2'd0;
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_frame(2, 1'b0);
        in_red = 8'h21; in_green = 8'h22; in_blue = 8'h23; in_valid = 1'b1;
        clk_en = 1'b0; ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #4;
            check("clken_in_ready_low", in_ready, 0);
            check("clken_out_valid_high", out_valid, 1);
        end
        #1;
        clk_en = 1'b1;
        send_frame(6, 1'b0);
        drain();

        // Degenerate sizes
        cfg_width = 12'd0; cfg_height = 12'd0; cfg_pattern = 2'd3;
        send_frame(3, 1'b0);
        cfg_width = 12'd2; cfg_height = 12'd0; cfg_pattern = 2'd0;
        send_frame(6, 1'b0);
        cfg_width = 12'd0; cfg_height = 12'd2; cfg_pattern = 2'd1;
        send_frame(3, 1'b0);
        drain();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
